// File: rtl/rgb_led_scheduler_pkg.sv
// rgb_led_scheduler_pkg: shared state encoding, colour constants and width helper
package rgb_led_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_e;
  localparam logic [2:0] OFF   = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rgb_led_scheduler_if.sv
// rgb_led_scheduler_if: requester bundle in, grant and LED pins out
interface rgb_led_scheduler_if
  import rgb_led_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PWM_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [3*N_REQ-1:0]      color;
  logic [PWM_W-1:0]        duty;
  logic [N_REQ-1:0]        grant;
  logic [clog2(N_REQ)-1:0] grantIdx;
  logic                    busy;
  logic [2:0]              ledRGB;
  modport master (output req, color, duty, input grant, grantIdx, busy, ledRGB);
  modport slave  (input req, color, duty, output grant, grantIdx, busy, ledRGB);
endinterface

// File: rtl/rgb_led_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set req at or above rr_ptr with wrap
module rr_arbiter
  import rgb_led_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);
  // scan from farthest to nearest so the closest request to rr_ptr wins
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % N_REQ]) winner = IW'((int'(rr_ptr) + i) % N_REQ);
    any_req = |req;
  end
endmodule

// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler: time-shares one RGB LED between requesters with dwell, gap and PWM dimming
module rgb_led_scheduler
  import rgb_led_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DWELL   = 10_000_000,
  parameter int DWELL_W = 24,
  parameter int PWM_W   = 8
) (
  input logic             sysClk,
  input logic             sysRst,
  rgb_led_scheduler_if.slave bus
);
  localparam int IW = clog2(N_REQ);
  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]      idx_q, idx_d, ptr_q, ptr_d, winner;
  logic               busy_q, busy_d, any_req, leave;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [2:0]         led_q, led_d;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (bus.req),
    .rr_ptr (ptr_q),
    .winner (winner),
    .any_req(any_req)
  );
  // a dropped request and an expired dwell on the same cycle collapse into one exit
  always_comb begin
    leave   = state_q == HOLD && (!bus.req[idx_q] || dwell_q == DWELL_W'(DWELL - 1));
    state_d = state_q == HOLD ? (leave ? GAP : HOLD) : (any_req ? HOLD : IDLE);
    grant_d = state_q == HOLD ? (leave ? '0 : grant_q) : (any_req ? N_REQ'(1) << winner : '0);
    idx_d   = state_q != HOLD && any_req ? winner : idx_q;
    busy_d  = state_d == HOLD;
    dwell_d = state_q == HOLD && !leave ? dwell_q + 1'b1 : '0;
    ptr_d   = leave ? (idx_q == IW'(N_REQ - 1) ? '0 : idx_q + 1'b1) : ptr_q;
    pwm_d   = pwm_q + 1'b1;
    // keyed on the next state so the pins go dark exactly on the GAP cycle
    led_d   = state_d == HOLD ? bus.color[3*idx_d +: 3] & {3{pwm_q < bus.duty}} : OFF;
  end
  always_ff @(posedge sysClk or posedge sysRst)
    if (sysRst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      dwell_q <= '0;
      pwm_q   <= '0;
      led_q   <= OFF;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      dwell_q <= dwell_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
    end
  assign bus.grant    = grant_q;
  assign bus.grantIdx = idx_q;
  assign bus.busy     = busy_q;
  assign bus.ledRGB   = led_q;
endmodule

// File: doc/rgb_led_scheduler.md
Name: rgb_led_scheduler

Overview:
Time-shares the board's single RGB LED between up to N_REQ requesters: switches, buttons, the heartbeat counter, and later the sigma-delta ADC status.
- A round-robin arbiter grants the LED to one requester for a fixed dwell time, then rotates.
- The granted 3-bit colour is PWM-dimmed by a global duty value before it drives the pins.
- Sits between the top-level I/O wiring and the ledRGB outputs.

Parameters:
N_REQ, 4, number of requesters (2..8).
DWELL, 10_000_000, hold time per grant in sysClk cycles (100 ms at 100 MHz); must be >= 2.
DWELL_W, 24, width of the dwell counter; must satisfy 2**DWELL_W > DWELL.
PWM_W, 8, width of the PWM counter and duty input.

Ports:
sysClk  input  1  system clock, all logic on rising edge.
sysRst  input  1  reset, asynchronous, active-high.
req  input  N_REQ  request bits, one per requester, level-sensitive.
color  input  3*N_REQ  colour of requester i on bits [3i+2:3i] (R,G,B).
duty  input  PWM_W  global brightness; LED is on while pwmCnt < duty.
grant  output  N_REQ  one-hot grant, registered.
grantIdx  output  clog2(N_REQ)  index of the current owner, registered.
busy  output  1  high while in HOLD.
ledRGB  output  3  dimmed colour to the pins, registered.

Behaviour:
- Interface: one clock (sysClk); reset (sysRst) is asynchronous and active-high.
- Reset values: grant=0, grantIdx=0, busy=0, ledRGB=0, state=IDLE, rrPtr=0, dwellCnt=0, pwmCnt=0.
- FSM states: IDLE, HOLD, GAP.
- IDLE:
  - req==0: stay in IDLE, outputs 0.
  - Any req bit set: the winner is the first set bit searching upward from rrPtr, wrapping modulo N_REQ.
  - Next cycle: state=HOLD, grant=onehot(winner), grantIdx=winner, busy=1, dwellCnt=0.
  - Latency from req to grant: 1 cycle.
- HOLD:
  - dwellCnt increments each cycle.
  - Owner drops req: exit to GAP on the next edge, regardless of dwellCnt.
  - dwellCnt==DWELL-1: exit to GAP.
  - On exit: rrPtr <= (grantIdx+1) mod N_REQ; grant=0, busy=0, dwellCnt=0.
- GAP: exactly one cycle with the LED forced off, to give a visible owner change without glitch.
  - Then re-arbitrate with the same rule as IDLE from the updated rrPtr.
  - Any req set: go to HOLD with the new winner, which may be the same requester if it is the only one asking.
  - req==0: go to IDLE.
- Fairness: with all N_REQ requesting, each holds DWELL cycles in turn, in the order 0,1,2,..., with one GAP cycle between holds.
- Simultaneous events: the owner dropping req on the same cycle its dwell expires is a single exit to GAP; rrPtr advances once.
- Colour path:
  - ledRGB <= (state==HOLD) ? color[owner] & {3{pwmCnt<duty}} : 0.
  - color is sampled live, not latched at grant; the pin is one cycle behind the input.
- PWM counter:
  - pwmCnt is free-running and wraps at 2**PWM_W-1 to 0; it is not reset by state changes.
  - duty=0 gives always off; duty=2**PWM_W-1 gives on for 255 of every 256 cycles.
- Reset mid-HOLD: all outputs go to 0 immediately (asynchronous). After release, arbitration restarts from rrPtr=0.
- Invariants:
  - grant is always 0 or one-hot.
  - grant!=0 if and only if busy==1.
  - grantIdx is valid only while busy==1 and holds its last value otherwise.

Decomposition:
- Package rgb_led_scheduler_pkg holds:
  - the state encoding (IDLE=2'd0, HOLD=2'd1, GAP=2'd2);
  - the colour constants (OFF=3'b000, RED=3'b100, GREEN=3'b010, BLUE=3'b001);
  - a clog2 helper.
- Sub-module rr_arbiter: purely combinational.
  - Inputs: req and rrPtr.
  - Outputs: winner index and anyReq.
  - Reusable for the later ADC channel scheduler.
- The FSM, dwell counter, PWM counter and output registers live in rgb_led_scheduler. Target size is about 200 RTL lines.

Test Plan:
- Reset: assert sysRst mid-run with req=4'b1111 -> grant, busy and ledRGB go to 0 without waiting for a clock edge. After release, req=4'b0100 gives grantIdx=2 one cycle later.
- Round-robin (DWELL=8, duty=255, req=4'b1111) -> the grant sequence is 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, with exactly 1 cycle of grant=0 between them.
- Single requester (req=4'b0010, color[5:3]=RED) -> 8 cycles at 100, 1 GAP cycle at 000, then grant=0010 again, repeating.
- Early release: the owner drops req at dwellCnt=3 with req[3] pending -> GAP on the next cycle, then grant=1000 with a fresh 8-cycle dwell.
- PWM: duty=64, single owner colour 111 -> ledRGB=111 for exactly 64 of every 256 cycles during HOLD. duty=0 gives ledRGB=0 throughout.
- Colour change during HOLD: the owner's colour goes from BLUE to GREEN at cycle t -> ledRGB shows GREEN at t+1, and grant is unchanged.
